// File: rtl/instruction_cache_pkg.sv
// Shared compute-unit types for the fetch/decode path: PC, warp id, active mask,
// encoded instruction, and the request record passed from the cache to the decoder.
package instruction_cache_pkg;

  localparam int IC_PC_W        = 32;
  localparam int IC_NUM_WARPS   = 8;
  localparam int IC_WARP_W      = 32;
  localparam int IC_INST_W      = 32;
  localparam int IC_LINE_INSTS  = 4;
  localparam int IC_NUM_LINES   = 16;
  localparam int IC_WID_W       = (IC_NUM_WARPS > 1) ? $clog2(IC_NUM_WARPS) : 1;

  typedef logic [IC_PC_W-1:0]   pc_t;
  typedef logic [IC_WID_W-1:0]  wid_t;
  typedef logic [IC_WARP_W-1:0] act_mask_t;
  typedef logic [IC_INST_W-1:0] enc_inst_t;

  typedef struct packed {
    pc_t       pc;
    act_mask_t act_mask;
    wid_t      warp_id;
  } ic_req_t;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the direct-mapped instruction cache: combinational
// read port, single write port, and a one-cycle invalidate of every valid bit.
module icache_line_store #(
  parameter int NumLines  = 16,
  parameter int IndexBits = 4,
  parameter int TagBits   = 26,
  parameter int LineWidth = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IndexBits-1:0] rd_index,
  output logic                 rd_valid,
  output logic [TagBits-1:0]   rd_tag,
  output logic [LineWidth-1:0] rd_line,
  input  logic                 wr_en,
  input  logic [IndexBits-1:0] wr_index,
  input  logic [TagBits-1:0]   wr_tag,
  input  logic [LineWidth-1:0] wr_line,
  input  logic                 set_valid,
  input  logic                 invalidate_all
);

  logic [NumLines-1:0]  valid;
  logic [TagBits-1:0]   tags  [NumLines];
  logic [LineWidth-1:0] lines [NumLines];

  // Only the valid bits are reset; tag and data contents are meaningless until a line is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (invalidate_all) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= set_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index]  <= wr_tag;
      lines[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_line  = lines[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped blocking instruction cache: one lookup per cycle, single outstanding
// line refill on a miss, then the lookup is replayed and hits.
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int PcWidth        = IC_PC_W,
  parameter int NumWarps       = IC_NUM_WARPS,
  parameter int WarpWidth      = IC_WARP_W,
  parameter int EncInstWidth   = IC_INST_W,
  parameter int CachelineInsts = IC_LINE_INSTS,
  parameter int NumLines       = IC_NUM_LINES,
  localparam int OffsetBits    = $clog2(CachelineInsts),
  localparam int IndexBits     = $clog2(NumLines),
  localparam int TagBits       = PcWidth - OffsetBits - IndexBits,
  localparam int WidWidth      = (NumWarps > 1) ? $clog2(NumWarps) : 1,
  localparam int LineWidth     = CachelineInsts * EncInstWidth
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          fe_valid_i,
  output logic                          ic_ready_o,
  input  logic [PcWidth-1:0]            fe_pc_i,
  input  logic [WarpWidth-1:0]          fe_act_mask_i,
  input  logic [WidWidth-1:0]           fe_warp_id_i,
  output logic                          ic_valid_o,
  input  logic                          dec_ready_i,
  output logic [PcWidth-1:0]            ic_pc_o,
  output logic [WarpWidth-1:0]          ic_act_mask_o,
  output logic [WidWidth-1:0]           ic_warp_id_o,
  output logic [EncInstWidth-1:0]       ic_inst_o,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic [PcWidth-OffsetBits-1:0] mem_req_addr_o,
  input  logic                          mem_rsp_valid_i,
  input  logic [LineWidth-1:0]          mem_rsp_data_i,
  input  logic                          flush_i
);

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT} state_t;

  state_t                 state, state_next;
  logic                   flush_pending;
  logic [PcWidth-1:0]     req_pc;
  logic [WarpWidth-1:0]   req_mask;
  logic [WidWidth-1:0]    req_wid;

  logic [OffsetBits-1:0]  req_offset;
  logic [IndexBits-1:0]   req_index;
  logic [TagBits-1:0]     req_tag;
  logic                   rd_valid;
  logic [TagBits-1:0]     rd_tag;
  logic [LineWidth-1:0]   rd_line;
  logic                   hit, lookup_hit, accept, refill, invalidate;

  assign req_offset = req_pc[OffsetBits-1:0];
  assign req_index  = req_pc[OffsetBits +: IndexBits];
  assign req_tag    = req_pc[PcWidth-1 -: TagBits];

  icache_line_store #(
    .NumLines (NumLines),
    .IndexBits(IndexBits),
    .TagBits  (TagBits),
    .LineWidth(LineWidth)
  ) u_store (
    .clk           (clk_i),
    .rst_n         (rst_ni),
    .rd_index      (req_index),
    .rd_valid      (rd_valid),
    .rd_tag        (rd_tag),
    .rd_line       (rd_line),
    .wr_en         (refill),
    .wr_index      (req_index),
    .wr_tag        (req_tag),
    .wr_line       (mem_rsp_data_i),
    .set_valid     (refill),
    .invalidate_all(invalidate)
  );

  assign hit        = rd_valid && (rd_tag == req_tag);
  assign lookup_hit = (state == LOOKUP) && hit;
  assign refill     = (state == MISS_WAIT) && mem_rsp_valid_i;
  assign invalidate = (state == IDLE) && flush_pending;
  // Gated by rst_ni so ready is low while reset is held, not just after it.
  assign ic_ready_o = rst_ni && !flush_pending &&
                      ((state == IDLE) || (lookup_hit && dec_ready_i));
  assign accept     = fe_valid_i && ic_ready_o;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept) state_next = LOOKUP;
      LOOKUP:    if (!hit) state_next = MISS_REQ;
                 else if (dec_ready_i) state_next = accept ? LOOKUP : IDLE;
      MISS_REQ:  if (mem_req_ready_i) state_next = MISS_WAIT;
      MISS_WAIT: if (mem_rsp_valid_i) state_next = LOOKUP;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      flush_pending <= 1'b0;
    end else begin
      state <= state_next;
      if (flush_i) flush_pending <= 1'b1;
      else if (invalidate) flush_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_pc   <= fe_pc_i;
      req_mask <= fe_act_mask_i;
      req_wid  <= fe_warp_id_i;
    end
  end

  // Outputs are forced to zero outside their valid windows so nothing unreset leaks out.
  assign ic_valid_o      = lookup_hit;
  assign ic_pc_o         = lookup_hit ? req_pc : '0;
  assign ic_act_mask_o   = lookup_hit ? req_mask : '0;
  assign ic_warp_id_o    = lookup_hit ? req_wid : '0;
  assign ic_inst_o       = lookup_hit ? rd_line[int'(req_offset)*EncInstWidth +: EncInstWidth] : '0;
  assign mem_req_valid_o = (state == MISS_REQ);
  assign mem_req_addr_o  = (state == MISS_REQ) ? req_pc[PcWidth-1:OffsetBits] : '0;

  unexpected_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rsp_valid_i |-> (state == MISS_WAIT))
    else $error("instruction_cache: refill response outside MISS_WAIT");

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: cold miss, hit streaming, backpressure,
// conflict eviction, flush during miss and reset during refill.
module tb_instruction_cache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fe_valid, ic_ready, ic_valid, dec_ready;
  logic [31:0]  fe_pc, fe_mask, ic_pc, ic_mask, ic_inst;
  logic [2:0]   fe_wid, ic_wid;
  logic         mem_req_valid, mem_req_ready, mem_rsp_valid, flush;
  logic [29:0]  mem_req_addr;
  logic [127:0] mem_rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] LINE_A = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [127:0] LINE_B = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
  localparam logic [127:0] LINE_C = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
  localparam logic [127:0] LINE_D = {32'hD3, 32'hD2, 32'hD1, 32'hD0};

  always #5 clk = ~clk;

  instruction_cache dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .fe_valid_i     (fe_valid),
    .ic_ready_o     (ic_ready),
    .fe_pc_i        (fe_pc),
    .fe_act_mask_i  (fe_mask),
    .fe_warp_id_i   (fe_wid),
    .ic_valid_o     (ic_valid),
    .dec_ready_i    (dec_ready),
    .ic_pc_o        (ic_pc),
    .ic_act_mask_o  (ic_mask),
    .ic_warp_id_o   (ic_wid),
    .ic_inst_o      (ic_inst),
    .mem_req_valid_o(mem_req_valid),
    .mem_req_ready_i(mem_req_ready),
    .mem_req_addr_o (mem_req_addr),
    .mem_rsp_valid_i(mem_rsp_valid),
    .mem_rsp_data_i (mem_rsp_data),
    .flush_i        (flush)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_valid"}, ic_valid, 0);
    chk({tag, "_memreq"}, mem_req_valid, 0);
    chk({tag, "_addr"}, mem_req_addr, 0);
    chk({tag, "_pc"}, ic_pc, 0);
    chk({tag, "_inst"}, ic_inst, 0);
    chk({tag, "_mask"}, ic_mask, 0);
    chk({tag, "_wid"}, ic_wid, 0);
  endtask

  // Fetch a PC expected to miss, serve the refill immediately, check the delivery.
  task automatic miss_fetch(input string tag, input logic [31:0] pc, input logic [2:0] wid,
                            input logic [31:0] mask, input logic [127:0] line,
                            input logic [29:0] exp_addr, input logic [31:0] exp_inst);
    fe_valid = 1; fe_pc = pc; fe_wid = wid; fe_mask = mask; dec_ready = 1; #1;
    chk({tag, "_ready"}, ic_ready, 1);
    tick(); fe_valid = 0; #1;
    chk({tag, "_lookup_valid"}, ic_valid, 0);
    tick();
    chk({tag, "_req_valid"}, mem_req_valid, 1);
    chk({tag, "_req_addr"}, mem_req_addr, exp_addr);
    mem_req_ready = 1; tick(); mem_req_ready = 0; #1;
    chk({tag, "_wait_req"}, mem_req_valid, 0);
    mem_rsp_valid = 1; mem_rsp_data = line; tick(); mem_rsp_valid = 0; #1;
    chk({tag, "_dvalid"}, ic_valid, 1);
    chk({tag, "_inst"}, ic_inst, exp_inst);
    chk({tag, "_pc"}, ic_pc, pc);
    chk({tag, "_wid"}, ic_wid, wid);
    chk({tag, "_mask"}, ic_mask, mask);
    tick();
    chk({tag, "_idle"}, ic_valid, 0);
  endtask

  initial begin
    rst_n = 0; fe_valid = 0; fe_pc = 0; fe_mask = 0; fe_wid = 0; dec_ready = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0; flush = 0;
    #2;
    outputs_zero("rst");
    chk("rst_ready", ic_ready, 0);
    tick(); tick();
    rst_n = 1; #1;
    outputs_zero("post_rst");
    chk("post_rst_ready", ic_ready, 1);

    // Cold miss, with one cycle of memory request backpressure
    fe_valid = 1; fe_pc = 32'h10; fe_wid = 3; fe_mask = 32'hFFFF_FFFF; dec_ready = 1; #1;
    chk("cold_ready", ic_ready, 1);
    tick(); fe_valid = 0; #1;
    chk("cold_lookup_valid", ic_valid, 0);
    chk("cold_lookup_memreq", mem_req_valid, 0);
    tick();
    chk("cold_req_valid", mem_req_valid, 1);
    chk("cold_req_addr", mem_req_addr, 30'h4);
    tick();
    chk("cold_req_hold", mem_req_valid, 1);
    chk("cold_req_addr_hold", mem_req_addr, 30'h4);
    mem_req_ready = 1; tick(); mem_req_ready = 0; #1;
    chk("cold_wait_req", mem_req_valid, 0);
    chk("cold_wait_valid", ic_valid, 0);
    mem_rsp_valid = 1; mem_rsp_data = LINE_A; tick(); mem_rsp_valid = 0; #1;
    chk("cold_valid", ic_valid, 1);
    chk("cold_inst", ic_inst, 32'hA0);
    chk("cold_wid", ic_wid, 3);
    chk("cold_mask", ic_mask, 32'hFFFF_FFFF);
    chk("cold_pc", ic_pc, 32'h10);

    // Hit streaming back-to-back while the cold-miss delivery retires
    fe_valid = 1; fe_pc = 32'h11; #1;
    chk("stream_ready", ic_ready, 1);
    tick(); fe_pc = 32'h12; #1;
    chk("stream1_valid", ic_valid, 1);
    chk("stream1_inst", ic_inst, 32'hA1);
    chk("stream1_memreq", mem_req_valid, 0);
    tick(); fe_pc = 32'h13; #1;
    chk("stream2_valid", ic_valid, 1);
    chk("stream2_inst", ic_inst, 32'hA2);
    chk("stream2_memreq", mem_req_valid, 0);
    tick(); fe_valid = 0; #1;
    chk("stream3_valid", ic_valid, 1);
    chk("stream3_inst", ic_inst, 32'hA3);
    chk("stream3_pc", ic_pc, 32'h13);
    chk("stream3_memreq", mem_req_valid, 0);
    tick();
    chk("stream_idle", ic_valid, 0);

    // Decoder backpressure for 5 cycles
    fe_valid = 1; fe_pc = 32'h12; fe_wid = 5; fe_mask = 32'h0000_00F0; #1;
    tick(); dec_ready = 0; fe_pc = 32'h13; fe_wid = 6; fe_mask = 32'h1; #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", ic_valid, 1);
      chk("bp_inst", ic_inst, 32'hA2);
      chk("bp_pc", ic_pc, 32'h12);
      chk("bp_wid", ic_wid, 5);
      chk("bp_mask", ic_mask, 32'h0000_00F0);
      chk("bp_ready", ic_ready, 0);
      tick();
    end
    dec_ready = 1; #1;
    chk("bp_release_ready", ic_ready, 1);
    tick(); fe_valid = 0; #1;
    chk("bp_next_valid", ic_valid, 1);
    chk("bp_next_inst", ic_inst, 32'hA3);
    chk("bp_next_wid", ic_wid, 6);
    tick();
    chk("bp_idle", ic_valid, 0);

    // Conflict eviction on index 4: 0x51 evicts 0x10's line, 0x10 refills again
    miss_fetch("evict_b", 32'h51, 3'd1, 32'h0000_FFFF, LINE_B, 30'h14, 32'hB1);
    miss_fetch("evict_a", 32'h10, 3'd2, 32'hFFFF_0000, LINE_A, 30'h4, 32'hA0);

    // Flush pulse during MISS_WAIT
    fe_valid = 1; fe_pc = 32'h20; fe_wid = 0; fe_mask = 32'hF; #1;
    tick(); fe_valid = 0; #1;
    tick();
    chk("fl_req_addr", mem_req_addr, 30'h8);
    mem_req_ready = 1; tick(); mem_req_ready = 0;
    flush = 1; tick(); flush = 0;
    mem_rsp_valid = 1; mem_rsp_data = LINE_C; tick(); mem_rsp_valid = 0;
    fe_valid = 1; fe_pc = 32'h10; fe_wid = 4; #1;
    chk("fl_deliver_valid", ic_valid, 1);
    chk("fl_deliver_inst", ic_inst, 32'hC0);
    chk("fl_deliver_ready", ic_ready, 0);
    tick();
    chk("fl_inval_valid", ic_valid, 0);
    chk("fl_inval_ready", ic_ready, 0);
    tick();
    chk("fl_after_ready", ic_ready, 1);
    tick(); fe_valid = 0; #1;
    chk("fl_refetch_valid", ic_valid, 0);
    tick();
    chk("fl_refetch_memreq", mem_req_valid, 1);
    chk("fl_refetch_addr", mem_req_addr, 30'h4);
    mem_req_ready = 1; tick(); mem_req_ready = 0;
    mem_rsp_valid = 1; mem_rsp_data = LINE_A; tick(); mem_rsp_valid = 0; #1;
    chk("fl_refetch_inst", ic_inst, 32'hA0);
    chk("fl_refetch_wid", ic_wid, 4);
    tick();

    // Reset during refill, late response arrives while reset is held
    fe_valid = 1; fe_pc = 32'h30; fe_wid = 7; #1;
    tick(); fe_valid = 0; #1;
    tick();
    mem_req_ready = 1; tick(); mem_req_ready = 0;
    rst_n = 0; #1;
    outputs_zero("midrst");
    chk("midrst_ready", ic_ready, 0);
    mem_rsp_valid = 1; mem_rsp_data = LINE_D; tick(); mem_rsp_valid = 0;
    rst_n = 1; #1;
    outputs_zero("midrst_after");
    chk("midrst_after_ready", ic_ready, 1);
    fe_valid = 1; fe_pc = 32'h30; #1;
    tick(); fe_valid = 0; #1;
    chk("midrst_line_invalid", ic_valid, 0);
    tick();
    chk("midrst_refetch_memreq", mem_req_valid, 1);
    chk("midrst_refetch_addr", mem_req_addr, 30'hC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
